// File: rtl/mem_arbiter.sv
// Two-client memory arbiter: instruction fetch and data port share one memory.
// A single command is outstanding at a time; fetch is forced after MAX_WAIT data wins.
module mem_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    input  logic        branch_sig,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    output logic        stallF,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    // state  | meaning
    // IDLE   | no command outstanding, grant decided combinationally
    // BUSY_F | fetch command outstanding, waiting for mem_rvalid
    // BUSY_D | data command outstanding, waiting for mem_rvalid
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_F = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [2:0] STARVE_MAX = 3'(MAX_WAIT);

    state_t     state_q, state_d;
    logic [2:0] starve_q, starve_d;
    logic       discard_q, discard_d;

    logic data_win;
    logic fetch_win;
    logic f_resp;
    logic d_resp;

    always_comb begin
        data_win  = (state_q == IDLE) && !reset && d_req
                    && !(f_req && (starve_q == STARVE_MAX));
        fetch_win = (state_q == IDLE) && !reset && f_req && !data_win;
        f_resp    = (state_q == BUSY_F) && mem_rvalid;
        d_resp    = (state_q == BUSY_D) && mem_rvalid;
    end

    always_comb begin
        f_gnt     = fetch_win;
        d_gnt     = data_win;
        mem_req   = fetch_win | data_win;
        mem_we    = data_win & d_we;
        mem_be    = 4'h0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (data_win) begin
            mem_be    = d_be;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (fetch_win) begin
            mem_be    = 4'hF;
            mem_addr  = f_addr;
        end

        // A redirect coinciding with the response also makes that word stale.
        f_rvalid = f_resp && !discard_q && !branch_sig;
        f_rdata  = f_rvalid ? mem_rdata : 32'h0;
        d_rvalid = d_resp;
        d_rdata  = d_resp ? mem_rdata : 32'h0;
        stallF   = f_req & ~f_rvalid;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (data_win)       state_d = BUSY_D;
                else if (fetch_win) state_d = BUSY_F;
            end
            BUSY_F:  if (mem_rvalid) state_d = IDLE;
            BUSY_D:  if (mem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        starve_d = starve_q;
        if (fetch_win)
            starve_d = 3'd0;
        else if (data_win && f_req && (starve_q < STARVE_MAX))
            starve_d = starve_q + 3'd1;

        discard_d = discard_q;
        if (f_resp)
            discard_d = 1'b0;
        else if (branch_sig && ((state_q == BUSY_F) || fetch_win))
            discard_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            starve_q  <= 3'd0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            discard_q <= discard_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single-transaction vector table plus
// hand sequences for starvation, redirect discard and mid-transaction reset.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        f_req;
    logic [31:0] f_addr;
    logic        branch_sig;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        stallF;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_pass  = 0;
    int n_total = 0;

    mem_arbiter #(.MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .branch_sig(branch_sig),
        .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata), .stallF(stallF),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string       name;
        logic        f_req;
        logic        d_req;
        logic        d_we;
        logic [31:0] f_addr;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_be;
        logic [31:0] rdata;
        int          lat;
        logic        exp_f;
        logic        exp_d;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    task automatic clear_inputs();
        f_req = 0; f_addr = 0; branch_sig = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1;
        @(negedge clk);
        reset = 0;
    endtask

    task automatic chk_no_grant(input string nm);
        chk({nm, ".f_gnt"}, 32'(f_gnt), 0);
        chk({nm, ".d_gnt"}, 32'(d_gnt), 0);
        chk({nm, ".mem_req"}, 32'(mem_req), 0);
        chk({nm, ".mem_addr"}, mem_addr, 0);
    endtask

    task automatic run_vec(input vec_t v);
        logic fv, dv;
        @(negedge clk);
        f_req = v.f_req; f_addr = v.f_addr;
        d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr;
        d_wdata = v.d_wdata; d_be = v.d_be;
        mem_rvalid = 0;
        #1;
        chk({v.name, ".f_gnt"}, 32'(f_gnt), 32'(v.exp_f));
        chk({v.name, ".d_gnt"}, 32'(d_gnt), 32'(v.exp_d));
        chk({v.name, ".mem_req"}, 32'(mem_req), 32'(v.exp_f | v.exp_d));
        chk({v.name, ".mem_we"}, 32'(mem_we), 32'(v.exp_we));
        chk({v.name, ".mem_be"}, 32'(mem_be), 32'(v.exp_be));
        chk({v.name, ".mem_addr"}, mem_addr, v.exp_addr);
        chk({v.name, ".mem_wdata"}, mem_wdata, v.exp_wdata);
        chk({v.name, ".stall0"}, 32'(stallF), 32'(v.f_req));
        for (int i = 1; i < v.lat; i++) begin
            @(negedge clk);
            #1;
            chk({v.name, ".wait_req"}, 32'(mem_req), 0);
            chk({v.name, ".wait_fv"}, 32'(f_rvalid), 0);
            chk({v.name, ".wait_stall"}, 32'(stallF), 32'(v.f_req));
        end
        @(negedge clk);
        mem_rvalid = 1; mem_rdata = v.rdata;
        #1;
        fv = v.exp_f;
        dv = v.exp_d;
        chk({v.name, ".f_rvalid"}, 32'(f_rvalid), 32'(fv));
        chk({v.name, ".f_rdata"}, f_rdata, fv ? v.rdata : 32'h0);
        chk({v.name, ".d_rvalid"}, 32'(d_rvalid), 32'(dv));
        chk({v.name, ".d_rdata"}, d_rdata, dv ? v.rdata : 32'h0);
        chk({v.name, ".resp_req"}, 32'(mem_req), 0);
        chk({v.name, ".resp_stall"}, 32'(stallF), 32'(v.f_req & ~fv));
        @(negedge clk);
        clear_inputs();
        #1;
        chk_no_grant({v.name, ".after"});
    endtask

    initial begin
        vecs[0] = '{"fetch_basic", 1'b1, 1'b0, 1'b0, 32'h8000, 32'h0, 32'h0, 4'h0,
                    32'h13, 2, 1'b1, 1'b0, 1'b0, 4'hF, 32'h8000, 32'h0};
        vecs[1] = '{"data_read", 1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h1234, 4'hF,
                    32'hDEADBEEF, 1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h200, 32'h1234};
        vecs[2] = '{"both_dwrite", 1'b1, 1'b1, 1'b1, 32'h8004, 32'h100, 32'hCAFE0001, 4'h3,
                    32'h55, 1, 1'b0, 1'b1, 1'b1, 4'h3, 32'h100, 32'hCAFE0001};
        vecs[3] = '{"no_req", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0,
                    32'h77, 1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
        vecs[4] = '{"fetch_lat3", 1'b1, 1'b0, 1'b0, 32'h8008, 32'h0, 32'h0, 4'h0,
                    32'h00100093, 3, 1'b1, 1'b0, 1'b0, 4'hF, 32'h8008, 32'h0};
        vecs[5] = '{"dwrite_top", 1'b0, 1'b1, 1'b1, 32'h0, 32'hFFFFFFFC, 32'hA5A5A5A5, 4'h8,
                    32'h0, 2, 1'b0, 1'b1, 1'b1, 4'h8, 32'hFFFFFFFC, 32'hA5A5A5A5};

        clear_inputs();
        reset = 1;
        #1;
        chk_no_grant("reset");
        chk("reset.f_rvalid", 32'(f_rvalid), 0);
        chk("reset.stall_lo", 32'(stallF), 0);
        f_req = 1;
        #1;
        chk("reset.stall_hi", 32'(stallF), 1);
        chk("reset.f_gnt_held", 32'(f_gnt), 0);
        f_req = 0;
        #1;
        reset = 0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // data-first with fetch pending; fetch follows after one bubble
        do_reset();
        @(negedge clk);
        f_req = 1; f_addr = 32'h8100;
        d_req = 1; d_we = 1; d_addr = 32'h100; d_be = 4'h3; d_wdata = 32'h11;
        #1;
        chk("pri.d_gnt", 32'(d_gnt), 1);
        chk("pri.f_gnt", 32'(f_gnt), 0);
        chk("pri.mem_we", 32'(mem_we), 1);
        chk("pri.mem_be", 32'(mem_be), 32'h3);
        @(negedge clk);
        d_req = 0; d_we = 0; mem_rvalid = 1; mem_rdata = 0;
        #1;
        chk("pri.d_rvalid", 32'(d_rvalid), 1);
        chk("pri.bubble_f_gnt", 32'(f_gnt), 0);
        @(negedge clk);
        mem_rvalid = 0;
        #1;
        chk("pri.f_gnt", 32'(f_gnt), 1);
        chk("pri.f_addr", mem_addr, 32'h8100);
        @(negedge clk);
        mem_rvalid = 1; mem_rdata = 32'h99;
        #1;
        chk("pri.f_rdata", f_rdata, 32'h99);
        @(negedge clk);
        clear_inputs();

        // continuous contention: 4 data grants then a forced fetch, repeating
        do_reset();
        for (int k = 0; k < 10; k++) begin
            logic exp_d;
            exp_d = (k % 5) != 4;
            @(negedge clk);
            mem_rvalid = 0;
            f_req = 1; f_addr = 32'h9000;
            d_req = 1; d_we = 0; d_addr = 32'(k * 4); d_be = 4'hF;
            #1;
            chk($sformatf("starve%0d.d_gnt", k), 32'(d_gnt), 32'(exp_d));
            chk($sformatf("starve%0d.f_gnt", k), 32'(f_gnt), 32'(!exp_d));
            @(negedge clk);
            mem_rvalid = 1; mem_rdata = 32'(k + 1);
            #1;
            chk($sformatf("starve%0d.rv", k), 32'(exp_d ? d_rvalid : f_rvalid), 1);
            chk($sformatf("starve%0d.busy_req", k), 32'(mem_req), 0);
        end
        @(negedge clk);
        clear_inputs();

        // redirect handling
        do_reset();
        @(negedge clk);
        f_req = 1; f_addr = 32'h9000;
        #1;
        chk("br.gnt1", 32'(f_gnt), 1);
        @(negedge clk);
        branch_sig = 1;
        @(negedge clk);
        branch_sig = 0; mem_rvalid = 1; mem_rdata = 32'h1111;
        #1;
        chk("br.drop_rv", 32'(f_rvalid), 0);
        chk("br.drop_rdata", f_rdata, 0);
        chk("br.drop_stall", 32'(stallF), 1);
        @(negedge clk);
        mem_rvalid = 0; f_addr = 32'hA000;
        #1;
        chk("br.gnt2", 32'(f_gnt), 1);
        chk("br.addr2", mem_addr, 32'hA000);
        @(negedge clk);
        mem_rvalid = 1; mem_rdata = 32'h2222;
        #1;
        chk("br.rv2", 32'(f_rvalid), 1);
        chk("br.rdata2", f_rdata, 32'h2222);
        @(negedge clk);
        mem_rvalid = 0; f_addr = 32'hB000; branch_sig = 1;
        #1;
        chk("br.gnt3", 32'(f_gnt), 1);
        @(negedge clk);
        branch_sig = 0; mem_rvalid = 1; mem_rdata = 32'h3333;
        #1;
        chk("br.gntcyc_rv", 32'(f_rvalid), 0);
        @(negedge clk);
        mem_rvalid = 0; f_req = 0;
        d_req = 1; d_addr = 32'h400; d_be = 4'hF;
        #1;
        chk("br.d_gnt", 32'(d_gnt), 1);
        @(negedge clk);
        d_req = 0; branch_sig = 1; mem_rvalid = 1; mem_rdata = 32'h4444;
        #1;
        chk("br.busyd_rv", 32'(d_rvalid), 1);
        chk("br.busyd_rdata", d_rdata, 32'h4444);
        @(negedge clk);
        branch_sig = 0; mem_rvalid = 0; f_req = 1; f_addr = 32'hC000;
        #1;
        chk("br.gnt4", 32'(f_gnt), 1);
        @(negedge clk);
        mem_rvalid = 1; mem_rdata = 32'h5555;
        #1;
        chk("br.rv4", 32'(f_rvalid), 1);
        chk("br.rdata4", f_rdata, 32'h5555);
        @(negedge clk);
        clear_inputs();

        // reset while a data command is outstanding
        @(negedge clk);
        d_req = 1; d_addr = 32'h300; d_be = 4'hF;
        #1;
        chk("rst.d_gnt", 32'(d_gnt), 1);
        @(negedge clk);
        reset = 1; d_req = 0; f_req = 1; mem_rvalid = 1; mem_rdata = 32'h66;
        #1;
        chk_no_grant("rst.in");
        chk("rst.in_d_rv", 32'(d_rvalid), 0);
        chk("rst.in_d_rdata", d_rdata, 0);
        chk("rst.in_stall", 32'(stallF), 1);
        @(negedge clk);
        reset = 0; f_req = 0; mem_rvalid = 1; mem_rdata = 32'h67;
        #1;
        chk("rst.late_rv", 32'(d_rvalid), 0);
        chk("rst.late_rdata", d_rdata, 0);
        chk("rst.late_req", 32'(mem_req), 0);
        @(negedge clk);
        mem_rvalid = 0; d_req = 1; d_addr = 32'h304;
        #1;
        chk("rst.regnt", 32'(d_gnt), 1);
        chk("rst.regnt_addr", mem_addr, 32'h304);
        @(negedge clk);
        d_req = 0; mem_rvalid = 1; mem_rdata = 32'h77;
        #1;
        chk("rst.rv", 32'(d_rvalid), 1);
        chk("rst.rdata", d_rdata, 32'h77);
        @(negedge clk);
        clear_inputs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
